// File: rtl/ctrl_pkg.sv
// Shared RV64I decode definitions: major opcodes, functional-unit encoding,
// immediate formats and the raw 32-bit immediate builder.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FU_ALU     = 3'd0;
  localparam logic [2:0] FU_BRU     = 3'd1;
  localparam logic [2:0] FU_LDU     = 3'd2;
  localparam logic [2:0] FU_STU     = 3'd3;
  localparam logic [2:0] FU_FENCE   = 3'd4;
  localparam logic [2:0] FU_SYS     = 3'd5;
  localparam logic [2:0] FU_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } immFmt_t;

  // Produces the immediate as a signed 32-bit value; callers sign-extend to XLEN.
  function automatic logic [31:0] buildImm(input immFmt_t fmt, input logic [31:0] inst);
    logic [31:0] imm;
    imm = 32'd0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational RV64I decoder: register indices, operand usage,
// immediate, functional-unit type and illegal detection.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            rs1Used_o,
  output logic            rs2Used_o,
  output logic            rdWen_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fuType_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic        known;
  logic        usesRs1;
  logic        usesRs2;
  logic        writesRd;
  logic        illegal;
  logic [2:0]  fuType;
  immFmt_t     immFmt;
  logic [31:0] imm32;
  logic        unusedFunct3;

  assign opcode       = inst_i[6:0];
  assign unusedFunct3 = ^inst_i[14:12];

  always_comb begin
    known    = 1'b1;
    usesRs1  = 1'b1;
    usesRs2  = 1'b0;
    writesRd = 1'b1;
    fuType   = FU_ALU;
    immFmt   = IMM_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        usesRs1 = 1'b0;
        immFmt  = IMM_U;
      end
      OPC_JAL: begin
        usesRs1 = 1'b0;
        fuType  = FU_BRU;
        immFmt  = IMM_J;
      end
      OPC_JALR: begin
        fuType = FU_BRU;
        immFmt = IMM_I;
      end
      OPC_BRANCH: begin
        usesRs2  = 1'b1;
        writesRd = 1'b0;
        fuType   = FU_BRU;
        immFmt   = IMM_B;
      end
      OPC_LOAD: begin
        fuType = FU_LDU;
        immFmt = IMM_I;
      end
      OPC_STORE: begin
        usesRs2  = 1'b1;
        writesRd = 1'b0;
        fuType   = FU_STU;
        immFmt   = IMM_S;
      end
      OPC_OP_IMM, OPC_OP_IMM32: immFmt = IMM_I;
      OPC_OP, OPC_OP32:         usesRs2 = 1'b1;
      OPC_MISC_MEM: begin
        writesRd = 1'b0;
        fuType   = FU_FENCE;
      end
      OPC_SYSTEM: begin
        fuType = FU_SYS;
        immFmt = IMM_I;
      end
      default: known = 1'b0;
    endcase
  end

  // Compressed-encoding low bits never reach a recognised opcode, but are
  // flagged explicitly so the intent survives future opcode additions.
  assign illegal = !known || (inst_i[1:0] != 2'b11);
  assign imm32   = illegal ? 32'd0 : buildImm(immFmt, inst_i);

  assign rs1_o     = inst_i[19:15];
  assign rs2_o     = inst_i[24:20];
  assign rd_o      = inst_i[11:7];
  assign rs1Used_o = usesRs1 && !illegal;
  assign rs2Used_o = usesRs2 && !illegal;
  assign rdWen_o   = writesRd && !illegal && (inst_i[11:7] != 5'd0);
  assign imm_o     = {{(XLEN-32){imm32[31]}}, imm32};
  assign fuType_o  = illegal ? FU_ILLEGAL : fuType;
  assign illegal_o = illegal;

endmodule

// File: rtl/ctrl_block.sv
// Single-stage decode: registers one decoded micro-op per cycle from the
// instruction buffer; fields hold while no valid instruction arrives.
module ctrl_block
  import ctrl_pkg::*;
#(
  parameter int PC_WIDTH = 48,
  parameter int XLEN     = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         ibuffer_instr_valid,
  input  logic [31:0]         ibuffer_inst_out,
  input  logic [PC_WIDTH-1:0] ibuffer_pc_out,
  output logic                ibuffer_inst_ready,
  output logic                dec_valid,
  output logic [PC_WIDTH-1:0] dec_pc,
  output logic [31:0]         dec_instr,
  output logic [4:0]          dec_rs1,
  output logic [4:0]          dec_rs2,
  output logic [4:0]          dec_rd,
  output logic                dec_rs1_used,
  output logic                dec_rs2_used,
  output logic                dec_rd_wen,
  output logic [XLEN-1:0]     dec_imm,
  output logic [2:0]          dec_fu_type,
  output logic                dec_illegal,
  output logic [31:0]         dec_count
);

  logic                inValid;
  logic                unusedValidBits;
  logic [4:0]          rs1, rs2, rd;
  logic                rs1Used, rs2Used, rdWen, illegal;
  logic [XLEN-1:0]     imm;
  logic [2:0]          fuType;

  logic                valid_q,   valid_d;
  logic [PC_WIDTH-1:0] pc_q,      pc_d;
  logic [31:0]         instr_q,   instr_d;
  logic [4:0]          rs1_q,     rs1_d;
  logic [4:0]          rs2_q,     rs2_d;
  logic [4:0]          rd_q,      rd_d;
  logic                rs1Used_q, rs1Used_d;
  logic                rs2Used_q, rs2Used_d;
  logic                rdWen_q,   rdWen_d;
  logic [XLEN-1:0]     imm_q,     imm_d;
  logic [2:0]          fuType_q,  fuType_d;
  logic                illegal_q, illegal_d;
  logic [31:0]         count_q,   count_d;

  assign inValid            = ibuffer_instr_valid[0];
  assign unusedValidBits    = ^ibuffer_instr_valid[31:1];
  assign ibuffer_inst_ready = 1'b1;

  ctrl_decoder #(.XLEN(XLEN)) uDecoder (
    .inst_i    (ibuffer_inst_out),
    .rs1_o     (rs1),
    .rs2_o     (rs2),
    .rd_o      (rd),
    .rs1Used_o (rs1Used),
    .rs2Used_o (rs2Used),
    .rdWen_o   (rdWen),
    .imm_o     (imm),
    .fuType_o  (fuType),
    .illegal_o (illegal)
  );

  always_comb begin
    valid_d   = inValid;
    pc_d      = pc_q;
    instr_d   = instr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rs1Used_d = rs1Used_q;
    rs2Used_d = rs2Used_q;
    rdWen_d   = rdWen_q;
    imm_d     = imm_q;
    fuType_d  = fuType_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (inValid) begin
      pc_d      = ibuffer_pc_out;
      instr_d   = ibuffer_inst_out;
      rs1_d     = rs1;
      rs2_d     = rs2;
      rd_d      = rd;
      rs1Used_d = rs1Used;
      rs2Used_d = rs2Used;
      rdWen_d   = rdWen;
      imm_d     = imm;
      fuType_d  = fuType;
      illegal_d = illegal;
      count_d   = count_q + 32'd1;
    end
  end

  // Reset wins over a valid input sampled on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1Used_q <= 1'b0;
      rs2Used_q <= 1'b0;
      rdWen_q   <= 1'b0;
      imm_q     <= '0;
      fuType_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rs1Used_q <= rs1Used_d;
      rs2Used_q <= rs2Used_d;
      rdWen_q   <= rdWen_d;
      imm_q     <= imm_d;
      fuType_q  <= fuType_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign dec_valid    = valid_q;
  assign dec_pc       = pc_q;
  assign dec_instr    = instr_q;
  assign dec_rs1      = rs1_q;
  assign dec_rs2      = rs2_q;
  assign dec_rd       = rd_q;
  assign dec_rs1_used = rs1Used_q;
  assign dec_rs2_used = rs2Used_q;
  assign dec_rd_wen   = rdWen_q;
  assign dec_imm      = imm_q;
  assign dec_fu_type  = fuType_q;
  assign dec_illegal  = illegal_q;
  assign dec_count    = count_q;

endmodule

// File: tb/tb_ctrl_block.sv
// Directed bench for ctrl_block: each step queues the hand-derived expected
// micro-op and compares it one cycle later against the registered outputs.
module tb_ctrl_block;

  typedef struct {
    logic        valid;
    logic [47:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1Used;
    logic        rs2Used;
    logic        rdWen;
    logic [63:0] imm;
    logic [2:0]  fu;
    logic        illegal;
    logic [31:0] count;
    bit          checkImm;
  } expect_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] ibuffer_instr_valid;
  logic [31:0] ibuffer_inst_out;
  logic [47:0] ibuffer_pc_out;
  logic        ibuffer_inst_ready;
  logic        dec_valid;
  logic [47:0] dec_pc;
  logic [31:0] dec_instr;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_rd_wen;
  logic [63:0] dec_imm;
  logic [2:0]  dec_fu_type;
  logic        dec_illegal;
  logic [31:0] dec_count;

  int      checks = 0;
  int      errors = 0;
  expect_t sbQueue[$];

  ctrl_block #(.PC_WIDTH(48), .XLEN(64)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .ibuffer_instr_valid (ibuffer_instr_valid),
    .ibuffer_inst_out    (ibuffer_inst_out),
    .ibuffer_pc_out      (ibuffer_pc_out),
    .ibuffer_inst_ready  (ibuffer_inst_ready),
    .dec_valid           (dec_valid),
    .dec_pc              (dec_pc),
    .dec_instr           (dec_instr),
    .dec_rs1             (dec_rs1),
    .dec_rs2             (dec_rs2),
    .dec_rd              (dec_rd),
    .dec_rs1_used        (dec_rs1_used),
    .dec_rs2_used        (dec_rs2_used),
    .dec_rd_wen          (dec_rd_wen),
    .dec_imm             (dec_imm),
    .dec_fu_type         (dec_fu_type),
    .dec_illegal         (dec_illegal),
    .dec_count           (dec_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares every registered output field.
  task automatic checkOutput(input string step);
    expect_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty observed=0 expected=1", step);
      return;
    end
    e = sbQueue.pop_front();
    checkField({step, ".valid"},   64'(dec_valid),    64'(e.valid));
    checkField({step, ".pc"},      64'(dec_pc),       64'(e.pc));
    checkField({step, ".instr"},   64'(dec_instr),    64'(e.instr));
    checkField({step, ".rs1"},     64'(dec_rs1),      64'(e.rs1));
    checkField({step, ".rs2"},     64'(dec_rs2),      64'(e.rs2));
    checkField({step, ".rd"},      64'(dec_rd),       64'(e.rd));
    checkField({step, ".rs1Used"}, 64'(dec_rs1_used), 64'(e.rs1Used));
    checkField({step, ".rs2Used"}, 64'(dec_rs2_used), 64'(e.rs2Used));
    checkField({step, ".rdWen"},   64'(dec_rd_wen),   64'(e.rdWen));
    if (e.checkImm) checkField({step, ".imm"}, dec_imm, e.imm);
    checkField({step, ".fu"},      64'(dec_fu_type),  64'(e.fu));
    checkField({step, ".illegal"}, 64'(dec_illegal),  64'(e.illegal));
    checkField({step, ".count"},   64'(dec_count),    64'(e.count));
    checkField({step, ".ready"},   64'(ibuffer_inst_ready), 64'd1);
  endtask

  // Upper valid bits carry junk so that only bit 0 may matter.
  task automatic applyStimulus(input string step, input logic rstN, input logic v,
                               input logic [31:0] inst, input logic [47:0] pc,
                               input expect_t e);
    reset_n             = rstN;
    ibuffer_instr_valid = {31'h1234_5678, v};
    ibuffer_inst_out    = inst;
    ibuffer_pc_out      = pc;
    sbQueue.push_back(e);
    @(posedge clock);
    #1;
    checkOutput(step);
  endtask

  initial begin
    expect_t zeroExp, addiExp, luiExp, beqExp, e;

    zeroExp = '{valid:1'b0, pc:48'h0, instr:32'h0, rs1:5'd0, rs2:5'd0, rd:5'd0,
                rs1Used:1'b0, rs2Used:1'b0, rdWen:1'b0, imm:64'h0, fu:3'd0,
                illegal:1'b0, count:32'd0, checkImm:1'b1};
    addiExp = '{valid:1'b1, pc:48'h1000, instr:32'h0050_0093, rs1:5'd0, rs2:5'd5, rd:5'd1,
                rs1Used:1'b1, rs2Used:1'b0, rdWen:1'b1, imm:64'd5, fu:3'd0,
                illegal:1'b0, count:32'd1, checkImm:1'b1};
    luiExp  = '{valid:1'b1, pc:48'h1004, instr:32'h1234_5137, rs1:5'd8, rs2:5'd3, rd:5'd2,
                rs1Used:1'b0, rs2Used:1'b0, rdWen:1'b1, imm:64'h0000_0000_1234_5000, fu:3'd0,
                illegal:1'b0, count:32'd2, checkImm:1'b1};
    beqExp  = '{valid:1'b1, pc:48'h1008, instr:32'hFE20_8EE3, rs1:5'd1, rs2:5'd2, rd:5'd29,
                rs1Used:1'b1, rs2Used:1'b1, rdWen:1'b0, imm:64'hFFFF_FFFF_FFFF_FFFC, fu:3'd1,
                illegal:1'b0, count:32'd3, checkImm:1'b1};

    applyStimulus("reset0", 1'b0, 1'b1, 32'h0050_0093, 48'h2000, zeroExp);
    applyStimulus("reset1", 1'b0, 1'b0, 32'h0, 48'h0, zeroExp);
    applyStimulus("addi", 1'b1, 1'b1, 32'h0050_0093, 48'h1000, addiExp);
    applyStimulus("lui", 1'b1, 1'b1, 32'h1234_5137, 48'h1004, luiExp);
    applyStimulus("beq", 1'b1, 1'b1, 32'hFE20_8EE3, 48'h1008, beqExp);

    e = beqExp;
    e.valid = 1'b0;
    applyStimulus("hold", 1'b1, 1'b0, 32'h0000_0013, 48'h9999, e);

    e = '{valid:1'b1, pc:48'h100C, instr:32'h0, rs1:5'd0, rs2:5'd0, rd:5'd0,
          rs1Used:1'b0, rs2Used:1'b0, rdWen:1'b0, imm:64'h0, fu:3'd7,
          illegal:1'b1, count:32'd4, checkImm:1'b0};
    applyStimulus("zeroInst", 1'b1, 1'b1, 32'h0, 48'h100C, e);

    e = '{valid:1'b1, pc:48'h1010, instr:32'h0000_0013, rs1:5'd0, rs2:5'd0, rd:5'd0,
          rs1Used:1'b1, rs2Used:1'b0, rdWen:1'b0, imm:64'h0, fu:3'd0,
          illegal:1'b0, count:32'd5, checkImm:1'b1};
    applyStimulus("addiX0", 1'b1, 1'b1, 32'h0000_0013, 48'h1010, e);

    e = '{valid:1'b1, pc:48'h1014, instr:32'h0050_0091, rs1:5'd0, rs2:5'd5, rd:5'd1,
          rs1Used:1'b0, rs2Used:1'b0, rdWen:1'b0, imm:64'h0, fu:3'd7,
          illegal:1'b1, count:32'd6, checkImm:1'b0};
    applyStimulus("lowBits", 1'b1, 1'b1, 32'h0050_0091, 48'h1014, e);

    e = '{valid:1'b1, pc:48'h1018, instr:32'h0020_A423, rs1:5'd1, rs2:5'd2, rd:5'd8,
          rs1Used:1'b1, rs2Used:1'b1, rdWen:1'b0, imm:64'd8, fu:3'd3,
          illegal:1'b0, count:32'd7, checkImm:1'b1};
    applyStimulus("sw", 1'b1, 1'b1, 32'h0020_A423, 48'h1018, e);

    applyStimulus("reset2", 1'b0, 1'b1, 32'h0050_0093, 48'h3000, zeroExp);
    for (int i = 1; i <= 3; i++) begin
      e = addiExp;
      e.pc = 48'h4000 + 48'(4 * i);
      e.count = 32'(i);
      applyStimulus("burst", 1'b1, 1'b1, 32'h0050_0093, 48'h4000 + 48'(4 * i), e);
    end
    applyStimulus("resetValid", 1'b0, 1'b1, 32'h0050_0093, 48'h5000, zeroExp);

    e = addiExp;
    e.pc = 48'h6000;
    applyStimulus("restart", 1'b1, 1'b1, 32'h0050_0093, 48'h6000, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
